// File: rtl/mem_router_if.sv
// CPU-side data bus between the master and mem_router.
// The router takes the slave modport.
interface mem_router_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    ready;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   write_data;
  logic [DATA_WIDTH/8-1:0] byte_enable;
  logic                    write_req;
  logic                    read_req;
  logic [DATA_WIDTH-1:0]   read_data;
  logic                    read_data_valid;

  modport master (
    input  ready, read_data, read_data_valid,
    output addr, write_data, byte_enable, write_req, read_req
  );

  modport slave (
    output ready, read_data, read_data_valid,
    input  addr, write_data, byte_enable, write_req, read_req
  );
endinterface

// File: rtl/mem_router.sv
// Address-decoding router from the CPU data bus to NUM_PORTS slaves.
// Read responses are returned in issue order by tracking issued reads in an order FIFO.
module mem_router #(
  parameter int unsigned NUM_PORTS          = 4,
  parameter int unsigned ADDR_WIDTH         = 32,
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned SEL_BITS           = 4,
  parameter int unsigned MAX_OUTSTANDING    = 4,
  parameter logic [DATA_WIDTH-1:0] UNMAPPED_READ_DATA = '0
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  mem_router_if.slave                          bus,
  output logic [ADDR_WIDTH-SEL_BITS-1:0]       port_addr,
  output logic [DATA_WIDTH-1:0]                port_write_data,
  output logic [DATA_WIDTH/8-1:0]              port_byte_enable,
  output logic [NUM_PORTS-1:0]                 port_write_req,
  output logic [NUM_PORTS-1:0]                 port_read_req,
  input  logic [NUM_PORTS-1:0]                 port_ready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]      port_read_data,
  input  logic [NUM_PORTS-1:0]                 port_read_data_valid,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_count,
  output logic                                 protocol_error
);

  localparam int unsigned TAG_W = $clog2(NUM_PORTS + 1);
  localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [TAG_W-1:0] UNMAPPED_TAG = TAG_W'(NUM_PORTS);

  logic [TAG_W-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             err_q;

  logic [SEL_BITS-1:0] sel;
  logic [TAG_W-1:0]    hit_tag;
  logic [TAG_W-1:0]    head_tag;
  logic                hit_ready, read_only, ready_c, fifo_full, fifo_empty;
  logic                push, pop, err_c, rvalid_c;
  logic [DATA_WIDTH-1:0] rdata_c;

  assign sel        = bus.addr[ADDR_WIDTH-1 -: SEL_BITS];
  assign fifo_full  = (count_q == CNT_W'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == '0);
  assign head_tag   = fifo_q[rd_ptr_q];

  assign port_addr        = bus.addr[ADDR_WIDTH-SEL_BITS-1:0];
  assign port_write_data  = bus.write_data;
  assign port_byte_enable = bus.byte_enable;

  // Request decode and forwarding; a simultaneous write wins over a read
  always_comb begin
    hit_tag        = UNMAPPED_TAG;
    hit_ready      = 1'b1;
    port_write_req = '0;
    port_read_req  = '0;
    read_only      = bus.read_req && !bus.write_req;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel == SEL_BITS'(i + 1)) begin
        hit_tag   = TAG_W'(i);
        hit_ready = port_ready[i];
      end
    end
    ready_c = hit_ready && !(read_only && fifo_full);
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel == SEL_BITS'(i + 1)) begin
        port_write_req[i] = bus.write_req && ready_c;
        port_read_req[i]  = read_only && ready_c;
      end
    end
    push = read_only && ready_c;
  end

  // Response path follows the FIFO head; responses from any other port are errors
  always_comb begin
    rvalid_c = 1'b0;
    rdata_c  = '0;
    err_c    = 1'b0;
    if (!fifo_empty && head_tag == UNMAPPED_TAG) begin
      rvalid_c = 1'b1;
      rdata_c  = UNMAPPED_READ_DATA;
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (port_read_data_valid[i]) begin
        if (!fifo_empty && head_tag == TAG_W'(i)) begin
          rvalid_c = 1'b1;
          rdata_c  = port_read_data[i*DATA_WIDTH +: DATA_WIDTH];
        end else begin
          err_c = 1'b1;
        end
      end
    end
    pop = rvalid_c;
  end

  assign bus.ready           = ready_c;
  assign bus.read_data       = rdata_c;
  assign bus.read_data_valid = rvalid_c;

  // Order FIFO; full is judged on the registered count only
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= hit_tag;
        wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      if (err_c) err_q <= 1'b1;
    end
  end

  assign outstanding_count = count_q;
  assign protocol_error    = err_q;

endmodule

// File: tb/tb_mem_router.sv
// Scoreboard bench for mem_router: expected read data is queued at issue and
// compared when the router returns a response.
module tb_mem_router;

  localparam int unsigned NP = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam logic [DW-1:0] UNM = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [AW-5:0]      port_addr;
  logic [DW-1:0]      port_write_data;
  logic [DW/8-1:0]    port_byte_enable;
  logic [NP-1:0]      port_write_req, port_read_req;
  logic [NP-1:0]      port_ready = '1;
  logic [NP*DW-1:0]   port_read_data = '0;
  logic [NP-1:0]      port_read_data_valid = '0;
  logic [2:0]         outstanding_count;
  logic               protocol_error;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] sb [$];

  mem_router_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_router #(
    .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_BITS(4),
    .MAX_OUTSTANDING(4), .UNMAPPED_READ_DATA(UNM)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .port_addr(port_addr), .port_write_data(port_write_data),
    .port_byte_enable(port_byte_enable), .port_write_req(port_write_req),
    .port_read_req(port_read_req), .port_ready(port_ready),
    .port_read_data(port_read_data), .port_read_data_valid(port_read_data_valid),
    .outstanding_count(outstanding_count), .protocol_error(protocol_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Response monitor: sampled mid-cycle, after inputs driven at negedge have settled
  always begin
    @(negedge clk);
    #3;
    if (bus.read_data_valid === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_rsp", 64'(bus.read_data), 64'hFFFF_FFFF_FFFF_FFFF);
      else chk("rdata", 64'(bus.read_data), 64'(sb.pop_front()));
    end else if (reset_n) begin
      chk("rdata_idle", 64'(bus.read_data), 64'h0);
    end
  end

  // Issue one read at the current negedge; queue its expected data when accepted
  task automatic rd(input logic [AW-1:0] a, input logic [NP-1:0] exp_strobe,
                    input logic [DW-1:0] exp_data, input bit do_push);
    bus.addr = a;
    bus.read_req = 1'b1;
    bus.write_req = 1'b0;
    #1;
    chk("rd_ready", 64'(bus.ready), 64'h1);
    chk("rd_strobe", 64'(port_read_req), 64'(exp_strobe));
    if (do_push) sb.push_back(exp_data);
    @(negedge clk);
    bus.read_req = 1'b0;
  endtask

  task automatic rsp(input int p, input logic [DW-1:0] d);
    port_read_data[p*DW +: DW] = d;
    port_read_data_valid[p] = 1'b1;
    @(negedge clk);
    port_read_data = '0;
    port_read_data_valid = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.addr = '0; bus.write_data = '0; bus.byte_enable = '0;
    bus.write_req = 1'b0; bus.read_req = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_count", 64'(outstanding_count), 64'h0);
    chk("rst_perr", 64'(protocol_error), 64'h0);
    chk("rst_ready", 64'(bus.ready), 64'h1);
    chk("rst_valid", 64'(bus.read_data_valid), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Single read to port0, answered two cycles after issue
    rd(32'h1000_0010, 4'b0001, 32'hCAFE_0001, 1'b1);
    #1;
    chk("t1_addr", 64'(port_addr), 64'h000_0010);
    chk("t1_strobe_once", 64'(port_read_req), 64'h0);
    chk("t1_count1", 64'(outstanding_count), 64'h1);
    @(negedge clk);
    rsp(0, 32'hCAFE_0001);
    #1;
    chk("t1_count0", 64'(outstanding_count), 64'h0);

    // Write to port1 stalled by port_ready for three cycles
    @(negedge clk);
    port_ready[1] = 1'b0;
    bus.addr = 32'h2000_0004; bus.write_data = 32'h55; bus.byte_enable = 4'b0001;
    bus.write_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("t2_ready_low", 64'(bus.ready), 64'h0);
      chk("t2_no_strobe", 64'(port_write_req), 64'h0);
      @(negedge clk);
    end
    port_ready[1] = 1'b1;
    #1;
    chk("t2_ready", 64'(bus.ready), 64'h1);
    chk("t2_wr_strobe", 64'(port_write_req), 64'b0010);
    chk("t2_wdata", 64'(port_write_data), 64'h55);
    chk("t2_be", 64'(port_byte_enable), 64'h1);
    chk("t2_addr", 64'(port_addr), 64'h000_0004);
    @(negedge clk);
    bus.write_req = 1'b0;
    #1;
    chk("t2_no_push", 64'(outstanding_count), 64'h0);

    // Out-of-order response from port0 is dropped and flagged
    @(negedge clk);
    rd(32'h3000_0100, 4'b0100, 32'hA000_0002, 1'b1);
    rd(32'h1000_0200, 4'b0001, 32'hB000_0000, 1'b1);
    rd(32'h3000_0300, 4'b0100, 32'hC000_0002, 1'b1);
    rsp(0, 32'hBAD0_0000);
    #1;
    chk("t3_perr", 64'(protocol_error), 64'h1);
    chk("t3_count3", 64'(outstanding_count), 64'h3);
    @(negedge clk);
    rsp(2, 32'hA000_0002);
    rsp(0, 32'hB000_0000);
    rsp(2, 32'hC000_0002);
    #1;
    chk("t3_count0", 64'(outstanding_count), 64'h0);

    // Fill the order FIFO against a port that withholds responses
    @(negedge clk);
    for (int k = 0; k < 4; k++) rd(32'h4000_0000 + 32'(k * 4), 4'b1000, 32'hD000_0000 + 32'(k), 1'b1);
    #1;
    chk("t4_count4", 64'(outstanding_count), 64'h4);
    @(negedge clk);
    bus.addr = 32'h4000_0010; bus.read_req = 1'b1;
    #1;
    chk("t4_full_ready", 64'(bus.ready), 64'h0);
    chk("t4_full_strobe", 64'(port_read_req), 64'h0);
    @(negedge clk);
    port_read_data[3*DW +: DW] = 32'hD000_0000;
    port_read_data_valid[3] = 1'b1;
    #1;
    chk("t4_still_full", 64'(bus.ready), 64'h0);
    @(negedge clk);
    port_read_data = '0;
    port_read_data_valid = '0;
    #1;
    chk("t4_count3", 64'(outstanding_count), 64'h3);
    chk("t4_ready_again", 64'(bus.ready), 64'h1);
    chk("t4_strobe", 64'(port_read_req), 64'b1000);
    sb.push_back(32'hD000_0004);
    @(negedge clk);
    bus.read_req = 1'b0;
    #1;
    chk("t4_count4b", 64'(outstanding_count), 64'h4);
    @(negedge clk);
    for (int k = 1; k < 5; k++) rsp(3, 32'hD000_0000 + 32'(k));
    #1;
    chk("t4_drained", 64'(outstanding_count), 64'h0);

    // Unmapped accesses: sel 0xF, then sel 5 and sel 0 (just outside the map)
    @(negedge clk);
    bus.addr = 32'hF000_0000; bus.read_req = 1'b1;
    #1;
    chk("t5_same_cycle_valid", 64'(bus.read_data_valid), 64'h0);
    chk("t5_no_strobe", 64'(port_read_req), 64'h0);
    chk("t5_ready", 64'(bus.ready), 64'h1);
    sb.push_back(UNM);
    @(negedge clk);
    bus.read_req = 1'b0;
    #1;
    chk("t5_next_valid", 64'(bus.read_data_valid), 64'h1);
    rd(32'h5000_0000, 4'b0000, UNM, 1'b1);
    rd(32'h0000_0040, 4'b0000, UNM, 1'b1);
    @(negedge clk);
    bus.addr = 32'hF000_0000; bus.write_req = 1'b1;
    #1;
    chk("t5_wr_ready", 64'(bus.ready), 64'h1);
    chk("t5_wr_no_strobe", 64'(port_write_req), 64'h0);
    @(negedge clk);
    bus.write_req = 1'b0;
    #1;
    chk("t5_count0", 64'(outstanding_count), 64'h0);

    // Write and read together: write only, no FIFO push
    @(negedge clk);
    bus.addr = 32'h1000_0008; bus.write_req = 1'b1; bus.read_req = 1'b1;
    #1;
    chk("wr_rd_wstrobe", 64'(port_write_req), 64'b0001);
    chk("wr_rd_rstrobe", 64'(port_read_req), 64'h0);
    @(negedge clk);
    bus.write_req = 1'b0; bus.read_req = 1'b0;
    #1;
    chk("wr_rd_no_push", 64'(outstanding_count), 64'h0);

    // Reset with two reads in flight; a late response then counts as an error
    @(negedge clk);
    rd(32'h2000_0000, 4'b0010, '0, 1'b0);
    rd(32'h2000_0004, 4'b0010, '0, 1'b0);
    #1;
    chk("t6_count2", 64'(outstanding_count), 64'h2);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_count", 64'(outstanding_count), 64'h0);
    chk("t6_rst_perr", 64'(protocol_error), 64'h0);
    chk("t6_rst_valid", 64'(bus.read_data_valid), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    rsp(1, 32'h1A7E_0000);
    #1;
    chk("t6_late_perr", 64'(protocol_error), 64'h1);
    chk("t6_late_count", 64'(outstanding_count), 64'h0);

    @(negedge clk);
    @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
